instr_fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the ALU/GPR execute datapath.
- Holds the 12-bit program counter and issues requests to instruction memory.
- Captures 18-bit instruction words into a one-entry IR buffer and hands them to execute over a valid/ready handshake.
- Services jump, call and return redirects from execute; call/return use an internal return-address stack.

---
 rtl/instr_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, instruction memory request, one-entry IR buffer, jump/call/return redirect.
// Latency: fetch ack loads IR on the same edge; with zero-wait memory, one instruction every 2 cycles.
// Backpressure: IR is held while ir_valid_o=1 and ir_ready_i=0; no new request is issued until it is consumed.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   inst_req_o/inst_addr_o        instruction memory read request and address (address = PC)
//   inst_ack_i/inst_dat_i         memory response, honoured only while a request is up
//   ir_o/ir_pc_o/ir_valid_o       buffered instruction and its fetch address to execute
//   ir_ready_i                    execute consumes the IR
//   jmp_i/call_i/ret_i/tgt_i      redirect pulses from execute (ret > call > jmp)
//   stack_ovf_o/stack_unf_o       sticky return-stack overflow / underflow flags
module instr_fetch_unit #(
  parameter int                 ADDR_W      = 12,
  parameter int                 INSTR_W     = 18,
  parameter int                 STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               inst_req_o,
  output logic [ADDR_W-1:0]  inst_addr_o,
  input  logic               inst_ack_i,
  input  logic [INSTR_W-1:0] inst_dat_i,
  output logic [INSTR_W-1:0] ir_o,
  output logic [ADDR_W-1:0]  ir_pc_o,
  output logic               ir_valid_o,
  input  logic               ir_ready_i,
  input  logic               jmp_i,
  input  logic               call_i,
  input  logic               ret_i,
  input  logic [ADDR_W-1:0]  tgt_i,
  output logic               stack_ovf_o,
  output logic               stack_unf_o
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  // One extra bit so the pointer can represent a completely full stack.
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic                vld_q, vld_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]   stack_d [STACK_DEPTH];

  logic            redirect;
  logic            ack_ok;
  logic [SP_W-1:0] sp_m1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    vld_d    = vld_q;
    ir_d     = ir_q;
    ir_pc_d  = ir_pc_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    sp_d     = sp_q;
    stack_d  = stack_q;
    sp_m1    = sp_q - SP_W'(1);
    redirect = ret_i | call_i | jmp_i;
    // An ack only counts against a request that is actually on the bus.
    ack_ok   = req_q & inst_ack_i & (state_q == FETCH);

    if (ret_i) begin
      if (sp_q == '0) begin
        unf_d = 1'b1;
        pc_d  = RESET_PC;
      end else begin
        pc_d = stack_q[sp_m1[IDX_W-1:0]];
        sp_d = sp_m1;
      end
    end else if (call_i) begin
      if (sp_q == SP_FULL) begin
        ovf_d = 1'b1;
      end else begin
        stack_d[sp_q[IDX_W-1:0]] = ir_pc_q + ADDR_W'(1);
        sp_d = sp_q + SP_W'(1);
      end
      pc_d = tgt_i;
    end else if (jmp_i) begin
      pc_d = tgt_i;
    end

    if (redirect) begin
      // Any same-cycle ack is dropped: neither IR nor PC increment happen.
      vld_d   = 1'b0;
      state_d = FETCH;
      req_d   = 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack_ok) begin
            ir_d    = inst_dat_i;
            ir_pc_d = pc_q;
            vld_d   = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = HOLD;
            req_d   = 1'b0;
          end else begin
            req_d = 1'b1;
          end
        end
        HOLD: begin
          if (ir_ready_i) begin
            vld_d   = 1'b0;
            state_d = FETCH;
            req_d   = 1'b1;
          end else begin
            req_d = 1'b0;
          end
        end
        default: begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      ir_q    <= '0;
      ir_pc_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      sp_q    <= sp_d;
    end
  end

  // Stack contents need no reset: the pointer alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    stack_q <= stack_d;
  end

  assign inst_req_o  = req_q;
  assign inst_addr_o = pc_q;
  assign ir_o        = ir_q;
  assign ir_pc_o     = ir_pc_q;
  assign ir_valid_o  = vld_q;
  assign stack_ovf_o = ovf_q;
  assign stack_unf_o = unf_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed vector table plus hand-written call-stack, wrap and reset sequences.
// Latency: each vector is one clock; outputs are compared 1 time unit after the rising edge.
// Backpressure: ir_ready_i is driven directly from the vectors.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        inst_req_o;
  logic [11:0] inst_addr_o;
  logic        inst_ack_i;
  logic [17:0] inst_dat_i;
  logic [17:0] ir_o;
  logic [11:0] ir_pc_o;
  logic        ir_valid_o;
  logic        ir_ready_i;
  logic        jmp_i, call_i, ret_i;
  logic [11:0] tgt_i;
  logic        stack_ovf_o, stack_unf_o;
  logic        ack_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  // Zero-wait memory: word at address A is A+1.
  assign inst_ack_i = inst_req_o & ack_en;
  assign inst_dat_i = {6'b0, inst_addr_o} + 18'd1;

  instr_fetch_unit dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inst_req_o  (inst_req_o),
    .inst_addr_o (inst_addr_o),
    .inst_ack_i  (inst_ack_i),
    .inst_dat_i  (inst_dat_i),
    .ir_o        (ir_o),
    .ir_pc_o     (ir_pc_o),
    .ir_valid_o  (ir_valid_o),
    .ir_ready_i  (ir_ready_i),
    .jmp_i       (jmp_i),
    .call_i      (call_i),
    .ret_i       (ret_i),
    .tgt_i       (tgt_i),
    .stack_ovf_o (stack_ovf_o),
    .stack_unf_o (stack_unf_o)
  );

  typedef struct {
    logic        rst, rdy, jmp, call, ret, ack;
    logic [11:0] tgt;
    logic        e_req;
    logic [11:0] e_addr;
    logic        e_vld;
    logic [17:0] e_ir;
    logic [11:0] e_irpc;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic rst, logic rdy, logic jmp, logic call, logic ret, logic ack,
                             logic [11:0] tgt, logic e_req, logic [11:0] e_addr, logic e_vld,
                             logic [17:0] e_ir, logic [11:0] e_irpc, logic e_ovf, logic e_unf);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.jmp = jmp; r.call = call; r.ret = ret; r.ack = ack; r.tgt = tgt;
    r.e_req = e_req; r.e_addr = e_addr; r.e_vld = e_vld; r.e_ir = e_ir; r.e_irpc = e_irpc;
    r.e_ovf = e_ovf; r.e_unf = e_unf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic drive(input logic rst, input logic rdy, input logic jmp, input logic call,
                       input logic ret, input logic ack, input logic [11:0] tgt);
    rst_i = rst; ir_ready_i = rdy; jmp_i = jmp; call_i = call; ret_i = ret; ack_en = ack; tgt_i = tgt;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; ir_ready_i = 1'b0; jmp_i = 1'b0; call_i = 1'b0; ret_i = 1'b0;
    ack_en = 1'b0; tgt_i = '0;

    //             rst rdy jmp cal ret ack tgt      req addr    vld ir        irpc    ovf unf
    vq.push_back(v(1, 0, 0, 0, 0, 0, 12'h000,  0, 12'h000, 0, 18'h00000, 12'h000, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 12'h000,  1, 12'h000, 0, 18'h00000, 12'h000, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 12'h000,  0, 12'h001, 1, 18'h00001, 12'h000, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 12'h000,  1, 12'h001, 0, 18'h00001, 12'h000, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 12'h000,  0, 12'h002, 1, 18'h00002, 12'h001, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 12'h000,  1, 12'h002, 0, 18'h00002, 12'h001, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 12'h000,  0, 12'h003, 1, 18'h00003, 12'h002, 0, 0));
    for (int k = 0; k < 5; k++)
      vq.push_back(v(0, 0, 0, 0, 0, 1, 12'h000, 0, 12'h003, 1, 18'h00003, 12'h002, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 12'h000,  1, 12'h003, 0, 18'h00003, 12'h002, 0, 0));
    // Jump collides with an ack: ack dropped, PC redirected.
    vq.push_back(v(0, 0, 1, 0, 0, 1, 12'h123,  1, 12'h123, 0, 18'h00003, 12'h002, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 12'h000,  0, 12'h124, 1, 18'h00124, 12'h123, 0, 0));
    vq.push_back(v(0, 0, 1, 0, 0, 1, 12'h010,  1, 12'h010, 0, 18'h00124, 12'h123, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 12'h000,  0, 12'h011, 1, 18'h00011, 12'h010, 0, 0));
    // Call from ir_pc=0x010 pushes 0x011; ret comes back there.
    vq.push_back(v(0, 0, 0, 1, 0, 1, 12'h040,  1, 12'h040, 0, 18'h00011, 12'h010, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 12'h000,  0, 12'h041, 1, 18'h00041, 12'h040, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 1, 1, 12'h000,  1, 12'h011, 0, 18'h00041, 12'h040, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 12'h000,  0, 12'h012, 1, 18'h00012, 12'h011, 0, 0));
    // Return with empty stack: underflow, restart at reset PC.
    vq.push_back(v(0, 0, 0, 0, 1, 1, 12'h000,  1, 12'h000, 0, 18'h00012, 12'h011, 0, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 12'h000,  0, 12'h001, 1, 18'h00001, 12'h000, 0, 1));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].rdy, vq[i].jmp, vq[i].call, vq[i].ret, vq[i].ack, vq[i].tgt);
      chk($sformatf("v%0d_req", i),  {31'b0, inst_req_o},  {31'b0, vq[i].e_req});
      chk($sformatf("v%0d_addr", i), {20'b0, inst_addr_o}, {20'b0, vq[i].e_addr});
      chk($sformatf("v%0d_vld", i),  {31'b0, ir_valid_o},  {31'b0, vq[i].e_vld});
      chk($sformatf("v%0d_ir", i),   {14'b0, ir_o},        {14'b0, vq[i].e_ir});
      chk($sformatf("v%0d_irpc", i), {20'b0, ir_pc_o},     {20'b0, vq[i].e_irpc});
      chk($sformatf("v%0d_ovf", i),  {31'b0, stack_ovf_o}, {31'b0, vq[i].e_ovf});
      chk($sformatf("v%0d_unf", i),  {31'b0, stack_unf_o}, {31'b0, vq[i].e_unf});
    end

    // Nine nested calls; each call is followed by a fetch so pushes are distinct.
    // Stack after eight: 0x001, 0x101..0x107. The ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 1, 0, 1, 12'h100 + 12'(i));
      chk($sformatf("call%0d_addr", i), {20'b0, inst_addr_o}, 32'h100 + i);
      chk($sformatf("call%0d_ovf", i),  {31'b0, stack_ovf_o}, (i == 8) ? 32'd1 : 32'd0);
      drive(0, 0, 0, 0, 0, 1, 12'h000);
      chk($sformatf("call%0d_irpc", i), {20'b0, ir_pc_o}, 32'h100 + i);
    end
    // ret and jmp together: pop wins.
    drive(0, 0, 1, 0, 1, 1, 12'h300);
    chk("retjmp_addr", {20'b0, inst_addr_o}, 32'h107);
    chk("retjmp_req",  {31'b0, inst_req_o},  32'd1);
    drive(0, 0, 0, 0, 0, 1, 12'h000);
    chk("retjmp_irpc", {20'b0, ir_pc_o}, 32'h107);
    chk("retjmp_ir",   {14'b0, ir_o},    32'h108);
    drive(0, 0, 0, 0, 1, 1, 12'h000);
    chk("ret2_addr",   {20'b0, inst_addr_o}, 32'h106);
    chk("ovf_sticky",  {31'b0, stack_ovf_o}, 32'd1);
    drive(0, 0, 0, 0, 0, 1, 12'h000);

    // PC wrap at 0xFFF.
    drive(0, 0, 1, 0, 0, 1, 12'hFFF);
    chk("wrap_addr0", {20'b0, inst_addr_o}, 32'hFFF);
    drive(0, 0, 0, 0, 0, 1, 12'h000);
    chk("wrap_irpc",  {20'b0, ir_pc_o},     32'hFFF);
    chk("wrap_ir",    {14'b0, ir_o},        32'h01000);
    chk("wrap_addr1", {20'b0, inst_addr_o}, 32'h000);
    drive(0, 1, 0, 0, 0, 1, 12'h000);
    chk("wrap_refetch", {20'b0, inst_addr_o}, 32'h000);
    chk("wrap_req",     {31'b0, inst_req_o},  32'd1);

    // Memory wait states: request and address held.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 12'h000);
      chk($sformatf("wait%0d_req", i),  {31'b0, inst_req_o},  32'd1);
      chk($sformatf("wait%0d_addr", i), {20'b0, inst_addr_o}, 32'h000);
      chk($sformatf("wait%0d_vld", i),  {31'b0, ir_valid_o},  32'd0);
    end
    // Reset while the ack arrives: ack ignored, everything cleared.
    drive(1, 0, 0, 0, 0, 1, 12'h000);
    chk("rst_req",  {31'b0, inst_req_o},  32'd0);
    chk("rst_vld",  {31'b0, ir_valid_o},  32'd0);
    chk("rst_ir",   {14'b0, ir_o},        32'd0);
    chk("rst_irpc", {20'b0, ir_pc_o},     32'd0);
    chk("rst_ovf",  {31'b0, stack_ovf_o}, 32'd0);
    chk("rst_unf",  {31'b0, stack_unf_o}, 32'd0);
    chk("rst_addr", {20'b0, inst_addr_o}, 32'd0);
    drive(0, 0, 0, 0, 0, 1, 12'h000);
    chk("post_rst_req",  {31'b0, inst_req_o},  32'd1);
    chk("post_rst_addr", {20'b0, inst_addr_o}, 32'd0);
    drive(0, 0, 0, 0, 0, 1, 12'h000);
    chk("post_rst_ir",   {14'b0, ir_o},       32'h00001);
    chk("post_rst_irpc", {20'b0, ir_pc_o},    32'h000);
    chk("post_rst_vld",  {31'b0, ir_valid_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
